// File: rtl/rice_param_select_if.sv
// Residual-in / Rice-parameter-out handshake between the FIR stage, this selector
// and the downstream bitstream encoder.
interface rice_param_select_if #(
  parameter int RES_WIDTH = 20,
  parameter int SUM_WIDTH = 36
);
  logic                        iValid;
  logic signed [RES_WIDTH-1:0] iResidual;
  logic                        oReady;
  logic [3:0]                  oK;
  logic [SUM_WIDTH-1:0]        oBits;
  logic                        oValid;
  logic                        oOverrun;

  modport master (
    output iValid, iResidual,
    input  oReady, oK, oBits, oValid, oOverrun
  );

  modport slave (
    input  iValid, iResidual,
    output oReady, oK, oBits, oValid, oOverrun
  );
endinterface

// File: rtl/rice_param_select.sv
// Accumulates the exact Rice-coded size of one residual block for every k in parallel,
// then scans the candidates one per cycle and reports the cheapest k and its size.
module rice_param_select #(
  parameter int BLOCK_SIZE = 4096,
  parameter int RES_WIDTH  = 20,
  parameter int MAX_K      = 14,
  parameter int SUM_WIDTH  = 36
) (
  input  logic                  iClock,
  input  logic                  iReset,
  input  logic                  iEnable,
  rice_param_select_if.slave    bus
);

  localparam int CNT_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;

  typedef enum logic [1:0] {ACCUM, DRAIN, SEARCH, DONE} state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_count;
  logic [3:0]           r_kIdx;
  logic                 r_pipeValid;
  logic [RES_WIDTH-1:0] r_pipeU;
  logic [SUM_WIDTH-1:0] r_acc [MAX_K+1];
  logic [SUM_WIDTH-1:0] r_best;
  logic [3:0]           r_bestK;
  logic [3:0]           r_k;
  logic [SUM_WIDTH-1:0] r_bits;
  logic                 r_valid;
  logic                 r_ready;
  logic                 r_overrun;

  logic [RES_WIDTH-1:0] w_u;
  logic [SUM_WIDTH-1:0] w_cost;

  // Zigzag: doubling then inverting on negative gives 2r or -2r-1 without an adder.
  assign w_u = {bus.iResidual[RES_WIDTH-2:0], 1'b0} ^ {RES_WIDTH{bus.iResidual[RES_WIDTH-1]}};

  always_comb begin
    w_cost = r_acc[r_kIdx] + (SUM_WIDTH'(r_kIdx) + SUM_WIDTH'(1)) * SUM_WIDTH'(BLOCK_SIZE);
  end

  // DRAIN lets the registered u of the last residual land in the accumulators before k=0 is compared.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_state     <= ACCUM;
      r_count     <= '0;
      r_kIdx      <= '0;
      r_pipeValid <= 1'b0;
      r_pipeU     <= '0;
      for (int k = 0; k <= MAX_K; k++) r_acc[k] <= '0;
      r_best      <= '0;
      r_bestK     <= '0;
      r_k         <= '0;
      r_bits      <= '0;
      r_valid     <= 1'b0;
      r_ready     <= 1'b1;
      r_overrun   <= 1'b0;
    end else if (iEnable) begin
      r_valid     <= 1'b0;
      r_pipeValid <= 1'b0;
      if (bus.iValid && !r_ready) r_overrun <= 1'b1;
      if (r_pipeValid) begin
        for (int k = 0; k <= MAX_K; k++) r_acc[k] <= r_acc[k] + SUM_WIDTH'(r_pipeU >> k);
      end
      case (r_state)
        ACCUM: begin
          if (bus.iValid) begin
            r_pipeValid <= 1'b1;
            r_pipeU     <= w_u;
            if (r_count == CNT_W'(BLOCK_SIZE - 1)) begin
              r_count <= '0;
              r_state <= DRAIN;
              r_ready <= 1'b0;
            end else begin
              r_count <= r_count + CNT_W'(1);
            end
          end
        end
        DRAIN: begin
          r_kIdx  <= '0;
          r_state <= SEARCH;
        end
        SEARCH: begin
          // Strict less-than keeps the smallest k on ties.
          if (r_kIdx == 4'd0 || w_cost < r_best) begin
            r_best  <= w_cost;
            r_bestK <= r_kIdx;
          end
          if (r_kIdx == 4'(MAX_K)) r_state <= DONE;
          else r_kIdx <= r_kIdx + 4'd1;
        end
        DONE: begin
          r_k     <= r_bestK;
          r_bits  <= r_best;
          r_valid <= 1'b1;
          r_ready <= 1'b1;
          r_state <= ACCUM;
          for (int k = 0; k <= MAX_K; k++) r_acc[k] <= '0;
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

  assign bus.oReady   = r_ready;
  assign bus.oK       = r_k;
  assign bus.oBits    = r_bits;
  assign bus.oValid   = r_valid;
  assign bus.oOverrun = r_overrun;

endmodule

// File: doc/rice_param_select.md
Name: rice_param_select

Overview:
- Stage directly downstream of the FIR filter bank.
- Consumes the residual stream of the winning predictor for one block.
- For every candidate Rice parameter k, computes the exact Rice-coded size of the block, then selects the k with the smallest size.
- Result feeds the residual/bitstream encoder.

Parameters:
BLOCK_SIZE, 4096, residuals per block (power of 2, ≤ 65536)
RES_WIDTH, 20, signed residual width
MAX_K, 14, largest Rice parameter evaluated (k = 0..MAX_K)
SUM_WIDTH, 36, width of per-k accumulators and of oBits

Ports:
iClock  in  1  clock, all logic on rising edge
iReset  in  1  synchronous, active-high reset
iEnable  in  1  clock enable; low = every register holds
iValid  in  1  iResidual valid this cycle
iResidual  in  RES_WIDTH  signed residual
oReady  out  1  high when a residual can be accepted
oK  out  4  selected Rice parameter
oBits  out  SUM_WIDTH  total coded bits for the block at oK (excludes partition header)
oValid  out  1  one-cycle strobe; oK/oBits valid
oOverrun  out  1  sticky; residual offered while oReady low

Behaviour:
- Reset (iReset=1 at a clock edge, iEnable ignored):
  - State to ACCUM.
  - Sample counter and all MAX_K+1 accumulators cleared.
  - oK=0, oBits=0, oValid=0, oOverrun=0, oReady=1.
  - Reset mid-block or mid-search discards all partial work; no oValid is produced for the aborted block.
- iEnable=0: all state, counters, accumulators and outputs hold. oValid keeps its value, so a strobe is stretched while stalled.
- Zigzag mapping: u = 2r for r ≥ 0; u = −2r−1 for r < 0. u is unsigned, RES_WIDTH bits.
- Size model: bits(k) = BLOCK_SIZE·(k+1) + Σ(u >> k).
- ACCUM state:
  - oReady=1.
  - On each accepted residual (iValid & iEnable), for every k in parallel: acc[k] += (u >> k), zero-extended to SUM_WIDTH.
  - Sample counter increments.
  - The residual that brings the count to BLOCK_SIZE moves the state to SEARCH on the same edge, and the counter wraps to 0.
  - Accumulator adds may be pipelined one stage. Any such stage must drain before the first compare.
- SEARCH state:
  - oReady=0.
  - One candidate per cycle, in order k=0..MAX_K.
  - cost = acc[k] + BLOCK_SIZE·(k+1).
  - Best is replaced only on strict less-than, so ties resolve to the smallest k.
  - After k=MAX_K, best is registered to oK/oBits and oValid=1 for one cycle.
  - In that same cycle: state returns to ACCUM, accumulators are cleared, and oReady=1.
- Latency: oValid rises exactly MAX_K+3 enabled cycles after the edge that accepted the last residual (17 with defaults). Calibrate compare pipelining to this count.
- oK/oBits hold their values until the next oValid or reset.
- Overrun: iValid=1 while oReady=0 (during SEARCH):
  - The residual is dropped and does not count toward the next block.
  - oOverrun is set and stays set until reset.
- Saturation: none. SUM_WIDTH=36 covers the worst case BLOCK_SIZE·2^RES_WIDTH + BLOCK_SIZE·(MAX_K+1).
- Back-to-back blocks: the first residual of the next block is accepted in the cycle oValid is high.

Test Plan:
1. 4096 residuals of 0, iValid continuous -> oValid exactly 17 cycles after last accept; oK=0, oBits=4096; oOverrun=0.
2. 4096 residuals of +1 (u=2; bits(0)=bits(1)=bits(2)=12288) -> oK=0, oBits=12288 (tie rule).
3. 4096 residuals of −100 (u=199; bits(7)=bits(8)=36864, all others larger) -> oK=7, oBits=36864.
4. 4096 residuals of −524288 (u=2^20−1; clamps at MAX_K) -> oK=14, oBits=4096·78=319488.
5. After a block of case 1, hold iValid=1 through SEARCH with value 5 -> oReady=0, oOverrun=1 sticky. Then feed a clean block of −100 -> oK=7, oBits=36864; dropped samples not counted.
6. Feed 2000 residuals of −100, pulse iReset, then 4096 residuals of 0, with iEnable toggled low every 3rd cycle -> no oValid from the aborted block; single oValid with oK=0, oBits=4096; the strobe stretches if iEnable=0 at that time.
